// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/forwarding unit.
package hazard_fwd_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int LCNT_W     = 3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: register addresses and status in, stage controls out.
interface hazard_fwd_ctrl_if
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_rs1_used, id_rs2_used;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic              ex_regwrite, ex_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;
    logic              br_taken, dmem_busy;

    logic              pc_en, if_id_en, id_ex_bubble, if_id_flush, ex_stall;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, br_taken, dmem_busy,
        input  pc_en, if_id_en, id_ex_bubble, if_id_flush, ex_stall,
               fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, br_taken, dmem_busy,
        output pc_en, if_id_en, id_ex_bubble, if_id_flush, ex_stall,
               fwd_a, fwd_b, stall_count
    );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Operand forwarding selector for one EX source; the younger EX/MEM result beats MEM/WB.
module hazard_fwd_ctrl_fwd_sel
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int FWD_EN = 1
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (FWD_EN != 0 && rs != '0) begin
            if (mem_regwrite && rs == mem_rd)
                sel = FWD_MEM;
            else if (wb_regwrite && rs == wb_rd)
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard unit: EX operand forwarding, load-use stall sequencer, dmem freeze and branch flush.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_fwd_ctrl_if.slave    hz
);

    localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_LAT - 1);

    hz_state_e         state, state_nxt, ret_state, ret_nxt, eff_state;
    logic [LCNT_W-1:0] lcnt, lcnt_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        sel_a, sel_b;
    logic              pc_en, if_id_en, bubble, flush, ex_stall;
    logic              rs1_ex, rs2_ex, rs1_mem, rs2_mem, load_use, legacy;

    assign rs1_ex  = hz.id_rs1_used && hz.id_rs1 != '0 && hz.id_rs1 == hz.ex_rd  && hz.ex_regwrite;
    assign rs2_ex  = hz.id_rs2_used && hz.id_rs2 != '0 && hz.id_rs2 == hz.ex_rd  && hz.ex_regwrite;
    assign rs1_mem = hz.id_rs1_used && hz.id_rs1 != '0 && hz.id_rs1 == hz.mem_rd && hz.mem_regwrite;
    assign rs2_mem = hz.id_rs2_used && hz.id_rs2 != '0 && hz.id_rs2 == hz.mem_rd && hz.mem_regwrite;

    assign load_use = hz.ex_memread && (rs1_ex || rs2_ex);
    assign legacy   = (FWD_EN == 0) && (rs1_ex || rs2_ex || rs1_mem || rs2_mem);

    // Once busy drops, MWAIT behaves exactly like the state it interrupted.
    assign eff_state = (state == MWAIT) ? ret_state : state;

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        lcnt_nxt  = lcnt;
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        bubble    = 1'b0;
        flush     = 1'b0;
        ex_stall  = 1'b0;
        if (!rst) begin
            if (hz.dmem_busy) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                ex_stall  = 1'b1;
                state_nxt = MWAIT;
                ret_nxt   = eff_state;
            end else if (hz.br_taken) begin
                flush     = 1'b1;
                bubble    = 1'b1;
                state_nxt = RUN;
                ret_nxt   = RUN;
                lcnt_nxt  = '0;
            end else if (eff_state == LSTALL) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                bubble    = 1'b1;
                lcnt_nxt  = lcnt - 1'b1;
                state_nxt = (lcnt == LCNT_W'(1)) ? RUN : LSTALL;
                ret_nxt   = RUN;
            end else begin
                state_nxt = RUN;
                ret_nxt   = RUN;
                if (load_use || legacy) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    bubble   = 1'b1;
                end
                // The detecting cycle is the first bubble; LSTALL supplies the rest.
                if (load_use && LOAD_LAT > 1) begin
                    state_nxt = LSTALL;
                    lcnt_nxt  = LCNT_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            lcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            lcnt      <= lcnt_nxt;
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    hazard_fwd_ctrl_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
        .rs(hz.ex_rs1), .mem_rd(hz.mem_rd), .mem_regwrite(hz.mem_regwrite),
        .wb_rd(hz.wb_rd), .wb_regwrite(hz.wb_regwrite), .sel(sel_a)
    );

    hazard_fwd_ctrl_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
        .rs(hz.ex_rs2), .mem_rd(hz.mem_rd), .mem_regwrite(hz.mem_regwrite),
        .wb_rd(hz.wb_rd), .wb_regwrite(hz.wb_regwrite), .sel(sel_b)
    );

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_ex_bubble = bubble;
    assign hz.if_id_flush  = flush;
    assign hz.ex_stall     = ex_stall;
    assign hz.fwd_a        = rst ? FWD_RF : sel_a;
    assign hz.fwd_b        = rst ? FWD_RF : sel_b;
    assign hz.stall_count  = stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: two configurations driven in lockstep against a pending-bubble model.
module tb_hazard_fwd_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, br_taken, dmem_busy;

    // u_a: forwarding, 3-cycle load latency; u_b: legacy interlock, 1-cycle latency, 4-bit counter
    hazard_fwd_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifa ();
    hazard_fwd_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifb ();

    hazard_fwd_ctrl #(.REG_AW(5), .FWD_EN(1), .LOAD_LAT(3), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .hz(ifa));
    hazard_fwd_ctrl #(.REG_AW(5), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(4))  u_b (.clk(clk), .rst(rst), .hz(ifb));

    assign ifa.id_rs1 = id_rs1;             assign ifb.id_rs1 = id_rs1;
    assign ifa.id_rs2 = id_rs2;             assign ifb.id_rs2 = id_rs2;
    assign ifa.id_rs1_used = id_rs1_used;   assign ifb.id_rs1_used = id_rs1_used;
    assign ifa.id_rs2_used = id_rs2_used;   assign ifb.id_rs2_used = id_rs2_used;
    assign ifa.ex_rs1 = ex_rs1;             assign ifb.ex_rs1 = ex_rs1;
    assign ifa.ex_rs2 = ex_rs2;             assign ifb.ex_rs2 = ex_rs2;
    assign ifa.ex_rd = ex_rd;               assign ifb.ex_rd = ex_rd;
    assign ifa.ex_regwrite = ex_regwrite;   assign ifb.ex_regwrite = ex_regwrite;
    assign ifa.ex_memread = ex_memread;     assign ifb.ex_memread = ex_memread;
    assign ifa.mem_rd = mem_rd;             assign ifb.mem_rd = mem_rd;
    assign ifa.mem_regwrite = mem_regwrite; assign ifb.mem_regwrite = mem_regwrite;
    assign ifa.wb_rd = wb_rd;               assign ifb.wb_rd = wb_rd;
    assign ifa.wb_regwrite = wb_regwrite;   assign ifb.wb_regwrite = wb_regwrite;
    assign ifa.br_taken = br_taken;         assign ifb.br_taken = br_taken;
    assign ifa.dmem_busy = dmem_busy;       assign ifb.dmem_busy = dmem_busy;

    logic [8:0]  obs_ctrl [2];
    logic [15:0] obs_sc   [2];
    assign obs_ctrl[0] = {ifa.pc_en, ifa.if_id_en, ifa.id_ex_bubble, ifa.if_id_flush, ifa.ex_stall, ifa.fwd_a, ifa.fwd_b};
    assign obs_ctrl[1] = {ifb.pc_en, ifb.if_id_en, ifb.id_ex_bubble, ifb.if_id_flush, ifb.ex_stall, ifb.fwd_a, ifb.fwd_b};
    assign obs_sc[0]   = ifa.stall_count;
    assign obs_sc[1]   = 16'(ifb.stall_count);

    int cfg_lat [2] = '{3, 1};
    int cfg_fwd [2] = '{1, 0};
    int cfg_max [2] = '{65535, 15};
    int pend    [2];
    int mcnt    [2];
    int checks   = 0;
    int failures = 0;
    logic [15:0] sa, sb;

    function automatic logic hit(input logic used, input logic [4:0] src, input logic [4:0] dst, input logic we);
        return used && we && src != 5'd0 && src == dst;
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs != 5'd0 && mem_regwrite && rs == mem_rd) return 2'b10;
        if (rs != 5'd0 && wb_regwrite && rs == wb_rd)   return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs1_used, id_rs2_used, ex_regwrite, ex_memread} = '0;
        {mem_regwrite, wb_regwrite, br_taken, dmem_busy} = '0;
    endtask

    // One clock: compare both DUTs against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [8:0] expv;
        logic [1:0] fa, fb;
        logic       pc, bub, fl, st, lu, leg;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            fa  = (cfg_fwd[d] != 0 && !rst) ? fwd_ref(ex_rs1) : 2'b00;
            fb  = (cfg_fwd[d] != 0 && !rst) ? fwd_ref(ex_rs2) : 2'b00;
            lu  = ex_memread && (hit(id_rs1_used, id_rs1, ex_rd, ex_regwrite) ||
                                 hit(id_rs2_used, id_rs2, ex_rd, ex_regwrite));
            leg = cfg_fwd[d] == 0 &&
                  (hit(id_rs1_used, id_rs1, ex_rd, ex_regwrite)   || hit(id_rs2_used, id_rs2, ex_rd, ex_regwrite) ||
                   hit(id_rs1_used, id_rs1, mem_rd, mem_regwrite) || hit(id_rs2_used, id_rs2, mem_rd, mem_regwrite));
            pc = 1'b1; bub = 1'b0; fl = 1'b0; st = 1'b0;
            if (rst) pend[d] = 0;
            else if (dmem_busy) begin pc = 1'b0; st = 1'b1; end
            else if (br_taken) begin bub = 1'b1; fl = 1'b1; pend[d] = 0; end
            else if (pend[d] > 0) begin pc = 1'b0; bub = 1'b1; pend[d]--; end
            else if (lu) begin pc = 1'b0; bub = 1'b1; pend[d] = cfg_lat[d] - 1; end
            else if (leg) begin pc = 1'b0; bub = 1'b1; end
            expv = {pc, pc, bub, fl, st, fa, fb};
            checks++;
            assert (obs_ctrl[d] === expv) else begin
                failures++;
                $error("FAIL ctrl dut%0d t=%0t observed=%b expected=%b", d, $time, obs_ctrl[d], expv);
            end
            checks++;
            assert (obs_sc[d] === 16'(mcnt[d])) else begin
                failures++;
                $error("FAIL stall_count dut%0d t=%0t observed=%0d expected=%0d", d, $time, obs_sc[d], mcnt[d]);
            end
            if (rst) mcnt[d] = 0;
            else if (!pc && mcnt[d] < cfg_max[d]) mcnt[d]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_setup();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd7; id_rs1_used = 1'b1; id_rs2 = 5'd2; id_rs2_used = 1'b1;
    endtask

    task automatic load_done();
        ex_memread = 1'b0; ex_regwrite = 1'b0;
    endtask

    initial begin
        pend = '{0, 0};
        mcnt = '{0, 0};
        clear_inputs();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;

        // forwarding: EX/MEM, MEM/WB, both (EX/MEM wins), x0
        ex_rs1 = 5'd5; ex_rs2 = 5'd1; mem_rd = 5'd5; mem_regwrite = 1'b1;
        cycle();
        mem_regwrite = 1'b0; wb_rd = 5'd5; wb_regwrite = 1'b1;
        cycle();
        mem_regwrite = 1'b1; ex_rs2 = 5'd5;
        cycle();
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        cycle();
        clear_inputs();

        // plain load-use
        sa = ifa.stall_count; sb = 16'(ifb.stall_count);
        load_use_setup(); cycle();
        load_done(); repeat (4) cycle();
        checks++;
        assert (16'(ifa.stall_count - sa) === 16'd3) else begin
            failures++; $error("FAIL lat3_delta observed=%0d expected=3", 16'(ifa.stall_count - sa));
        end
        checks++;
        assert (4'(ifb.stall_count - sb[3:0]) === 4'd1) else begin
            failures++; $error("FAIL lat1_delta observed=%0d expected=1", 4'(ifb.stall_count - sb[3:0]));
        end

        // load-use with dmem_busy held 4 cycles mid-LSTALL
        sa = ifa.stall_count;
        load_use_setup(); cycle();
        load_done(); cycle();
        dmem_busy = 1'b1; repeat (4) cycle();
        dmem_busy = 1'b0; repeat (3) cycle();
        checks++;
        assert (16'(ifa.stall_count - sa) === 16'd7) else begin
            failures++; $error("FAIL lstall_mwait_delta observed=%0d expected=7", 16'(ifa.stall_count - sa));
        end

        // branch aborts LSTALL
        load_use_setup(); cycle();
        load_done(); br_taken = 1'b1; cycle();
        br_taken = 1'b0; repeat (2) cycle();
        clear_inputs();

        // legacy EX/MEM hazard on rs2, then same with rs2 unused
        mem_rd = 5'd9; mem_regwrite = 1'b1; id_rs2 = 5'd9; id_rs2_used = 1'b1;
        cycle();
        id_rs2_used = 1'b0;
        cycle();
        clear_inputs();

        // reset in LSTALL, then in MWAIT
        load_use_setup(); cycle();
        load_done(); rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        dmem_busy = 1'b1; cycle(); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; dmem_busy = 1'b0; cycle();
        clear_inputs();

        // counter saturation on the 4-bit instance
        dmem_busy = 1'b1; repeat (20) cycle();
        dmem_busy = 1'b0;
        checks++;
        assert (ifb.stall_count === 4'hf) else begin
            failures++; $error("FAIL saturate observed=%0d expected=15", ifb.stall_count);
        end
        cycle();

        // randomized traffic on a small register window to provoke matches
        repeat (600) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
            ex_regwrite  = 1'($urandom_range(0, 1)); ex_memread  = ($urandom_range(0, 2) == 0);
            mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
            br_taken  = ($urandom_range(0, 7) == 0);
            dmem_busy = ($urandom_range(0, 5) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Next-generation hazard unit for the 5-stage pipeline. It replaces full interlocking with EX/MEM and MEM/WB operand forwarding. It keeps a parametrised load-use stall sequencer, freezes the pipe on data-memory wait, and flushes on taken branches. It sits beside the ID and EX stages and drives the PC/IF-ID enables, the ID/EX bubble mux, the IF/ID flush and the EX operand-select muxes.

Parameters:
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding enabled; 0 = legacy full interlock (stall on any ID/EX or EX/MEM match)
LOAD_LAT, 1, bubble cycles inserted on a load-use hazard (1..7)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
id_rs1, id_rs2  in  REG_AW  source registers of the instruction in IF/ID
id_rs1_used, id_rs2_used  in  1  source actually read by the decoded op
ex_rs1, ex_rs2  in  REG_AW  source registers held in ID/EX
ex_rd  in  REG_AW  destination in ID/EX
ex_regwrite, ex_memread  in  1  ID/EX writes a register / is a load
mem_rd  in  REG_AW  destination in EX/MEM
mem_regwrite  in  1  EX/MEM writes a register
wb_rd  in  REG_AW  destination in MEM/WB
wb_regwrite  in  1  MEM/WB writes a register
br_taken  in  1  taken branch/jump resolved in EX
dmem_busy  in  1  data memory not ready; the MEM stage must hold
pc_en, if_id_en  out  1  advance PC / IF-ID register
id_ex_bubble  out  1  insert a NOP into ID/EX
if_id_flush  out  1  clear IF-ID to a NOP
ex_stall  out  1  hold ID/EX, EX/MEM and MEM/WB
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
stall_count  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM state RUN, stall counter 0, stall_count 0. During reset the outputs are pc_en=1, if_id_en=1, all other control outputs 0, fwd_a=fwd_b=00.
- x0: register 0 never matches and never forwards.
- Match definition: a source matches a destination when the source's *_used bit is 1 (ID-side sources only), the addresses are equal, the address is non-zero, and the producer's regwrite is 1.
- Forwarding (combinational, FWD_EN=1):
  - fwd_a=10 when ex_rs1 matches mem_rd.
  - Otherwise fwd_a=01 when ex_rs1 matches wb_rd.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules with ex_rs2.
  - EX/MEM always wins over MEM/WB.
  - With FWD_EN=0, fwd_a and fwd_b are tied to 00.
- Load-use hazard: ex_memread=1 and an ID source matches ex_rd. Legacy hazard (FWD_EN=0 only): an ID source matches ex_rd or mem_rd.
- FSM states: RUN, LSTALL, MWAIT.
  - RUN, dmem_busy=1 → MWAIT.
  - RUN, load-use hazard → LSTALL, counter loaded with LOAD_LAT-1. In the detecting cycle: pc_en=if_id_en=0, id_ex_bubble=1.
  - LSTALL: same outputs as the detecting cycle. Counter decrements each cycle; leave to RUN when counter=0. Total bubbles = LOAD_LAT.
  - MWAIT: pc_en=if_id_en=0, ex_stall=1. Stays until dmem_busy=0, then returns to the state held before entry; the LSTALL counter is frozen during MWAIT.
  - Legacy hazard is combinational in RUN: stall plus bubble each cycle it holds. No FSM entry.
- Priority, highest first: dmem_busy, then br_taken, then load-use/legacy, then normal.
  - On br_taken with dmem_busy=0: if_id_flush=1, id_ex_bubble=1, pc_en=1.
  - br_taken aborts any LSTALL: state → RUN, counter cleared.
- stall_count: increments every cycle pc_en=0 and saturates at all-ones.
- Mid-operation reset: any state returns to RUN on the next edge; the counter is cleared.

Decomposition:
- Shared package, pipeline pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - state encoding RUN/LSTALL/MWAIT
  - REG_AW default
- One sub-module, fwd_sel: pure combinational forwarding selector for one operand, instantiated twice (fwd_a, fwd_b).

Test Plan:
- Back-to-back ALU ops (add x5; sub x6,x5,x1) → fwd_a=10, no stall. Retry one instruction apart → fwd_a=01. x0 destination → 00.
- lw x7 then add x8,x7,x2, LOAD_LAT=1 → exactly one cycle with pc_en=0 and id_ex_bubble=1. Re-run with LOAD_LAT=3 → three cycles; stall_count +3.
- lw/use stall with dmem_busy held 4 cycles mid-LSTALL → ex_stall=1 for 4 cycles, LSTALL resumes with its remaining count, total pc_en=0 cycles = LOAD_LAT+4.
- br_taken asserted during LSTALL → that cycle if_id_flush=1, pc_en=1; next cycle state RUN with no residual bubble.
- FWD_EN=0, producer in EX/MEM matching id_rs2 (id_rs2_used=1) → stall plus bubble. Same with id_rs2_used=0 → no stall.
- rst asserted in LSTALL and in MWAIT → next cycle pc_en=1, all other controls 0. Force stall_count near max → saturates at 2^CNT_W-1.
